// File: rtl/sel_acc_pkg.sv
// Shared state encoding for the select-result window accumulator.
package sel_acc_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/sel_acc_win_cnt.sv
// Sample index within the current window: increments on accept, wraps after WIN_LEN-1,
// and can restart at 1 when a new window's first sample lands in a transfer cycle.
module sel_acc_win_cnt #(
   parameter int unsigned WIN_LEN = 8,
   parameter int unsigned IDX_W   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic             load_one,
   output logic [IDX_W-1:0] idx,
   output logic             last
);

   logic [IDX_W-1:0] idx_q, idx_d;

   assign last = (idx_q == IDX_W'(WIN_LEN - 1));
   assign idx  = idx_q;

   always_comb begin
      idx_d = idx_q;
      if (clr) begin
         idx_d = '0;
      end else if (load_one) begin
         idx_d = IDX_W'(1);
      end else if (inc) begin
         idx_d = last ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/sel_result_accumulator.sv
// Counts ones in fixed windows of WIN_LEN accepted 1-bit samples; one held result per window.
// Define SEL_ACC_OVERLAP_EN to accept the next window's first sample during the transfer cycle.
module sel_result_accumulator
   import sel_acc_pkg::*;
#(
   parameter int unsigned WIN_LEN = 8,
   parameter int unsigned CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   output logic [CNT_W-1:0] out_count,
   input  logic             out_ready,
   output logic             busy
);

   localparam int unsigned IDX_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

`ifdef SEL_ACC_OVERLAP_EN
   localparam bit OVERLAP = 1'b1;
`else
   localparam bit OVERLAP = 1'b0;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_valid_q, out_valid_d;
   logic             cnt_inc, cnt_load;
   logic             accept;
   logic             last;
   logic [IDX_W-1:0] idx;

   sel_acc_win_cnt #(
      .WIN_LEN (WIN_LEN),
      .IDX_W   (IDX_W)
   ) u_win_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .inc      (cnt_inc),
      .load_one (cnt_load),
      .idx      (idx),
      .last     (last)
   );

   assign in_ready  = (state_q == ST_ACCUM) | (OVERLAP & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign out_count = out_count_q;
   assign busy      = (idx != '0);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      out_count_d = out_count_q;
      out_valid_d = out_valid_q;
      cnt_inc     = 1'b0;
      cnt_load    = 1'b0;
      if (clr) begin
         // Drops any held result, even if out_ready is high this cycle.
         state_d     = ST_ACCUM;
         acc_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_ACCUM: begin
               if (accept) begin
                  cnt_inc = 1'b1;
                  if (last) begin
                     out_count_d = acc_q + CNT_W'(in_bit);
                     out_valid_d = 1'b1;
                     acc_d       = '0;
                     state_d     = ST_HOLD;
                  end else begin
                     acc_d = acc_q + CNT_W'(in_bit);
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = ST_ACCUM;
                  // Only reachable with overlap: sample 0 of the next window.
                  if (accept) begin
                     acc_d    = CNT_W'(in_bit);
                     cnt_load = 1'b1;
                  end
               end
            end
            default: state_d = ST_ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_sel_result_accumulator.sv
// Scoreboard bench for sel_result_accumulator: directed cases plus random traffic.
module tb_sel_result_accumulator;

   localparam int WIN_LEN = 8;
   localparam int CNT_W   = 4;
`ifdef SEL_ACC_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             clr = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_bit = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [CNT_W-1:0] out_count;
   logic             out_ready = 1'b0;
   logic             busy;

   sel_result_accumulator #(
      .WIN_LEN (WIN_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_count (out_count),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: samples collected in the open window, and a pending result flag.
   int win_n    = 0;
   int win_ones = 0;
   bit pending  = 1'b0;
   int exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_clear();
      win_n    = 0;
      win_ones = 0;
      pending  = 1'b0;
      exp_q.delete();
   endtask

   // One clock cycle: check registered outputs, drive inputs, advance the model.
   task automatic step(input bit v, input bit b, input bit r, input bit c);
      bit exp_rdy;
      chk("busy", int'(busy), int'(win_n != 0));
      chk("out_valid", int'(out_valid), int'(pending));
      in_valid  = v;
      in_bit    = v ? b : 1'($urandom);
      out_ready = r;
      clr       = c;
      exp_rdy   = !pending || (OVL && r);
      #1;
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      if (c) begin
         if (pending) void'(exp_q.pop_back());
         pending  = 1'b0;
         win_n    = 0;
         win_ones = 0;
      end else begin
         if (pending && r) pending = 1'b0;
         if (v && exp_rdy) begin
            win_n++;
            win_ones += int'(b);
            if (win_n == WIN_LEN) begin
               exp_q.push_back(win_ones);
               pending  = 1'b1;
               win_n    = 0;
               win_ones = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_count", int'(out_count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      model_clear();
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: pops the scoreboard on every real transfer, and checks held results stay put.
   bit               prev_hold = 1'b0;
   logic [CNT_W-1:0] prev_count = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && out_valid) chk("hold_stable", int'(out_count), int'(prev_count));
         if (out_valid && out_ready && !clr) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else chk("out_count", int'(out_count), exp_q.pop_front());
         end
         prev_hold  = out_valid && !out_ready && !clr;
         prev_count = out_count;
      end
   end

   initial begin
      bit pat[8] = '{1, 0, 1, 1, 0, 0, 1, 1};
      #2;
      do_reset();
      @(posedge clk);
      #1;

      // Mixed-bit window, back-to-back, downstream always ready.
      foreach (pat[i]) step(1, pat[i], 1, 0);
      repeat (2) step(0, 0, 1, 0);

      // All ones, then five cycles of backpressure while the valid input keeps pushing.
      for (int i = 0; i < WIN_LEN; i++) step(1, 1, 0, 0);
      repeat (5) step(1, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);

      // Gapped input.
      for (int i = 0; i < 2 * WIN_LEN; i++) step(i % 2 == 0, 1, 1, 0);
      repeat (2) step(0, 0, 1, 0);

      // Clear mid-window with a sample offered in the same cycle, then a zero window.
      step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 1, 1, 0); step(1, 0, 1, 0);
      step(1, 1, 1, 1);
      for (int i = 0; i < WIN_LEN; i++) step(1, 0, 1, 0);
      repeat (2) step(0, 0, 1, 0);

      // Clear while a result is held and out_ready is high: result must vanish.
      for (int i = 0; i < WIN_LEN; i++) step(1, 1, 0, 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);

      // Asynchronous reset while a result is held.
      for (int i = 0; i < WIN_LEN; i++) step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      do_reset();

      // Continuous traffic: three windows of ones.
      for (int i = 0; i < 3 * WIN_LEN; i++) step(1, 1, 1, 0);
      repeat (3) step(0, 0, 1, 0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(9, 0) < 7, 1'($urandom), $urandom_range(9, 0) < 6,
              $urandom_range(39, 0) == 0);
      end
      in_valid = 1'b0;
      repeat (3) step(0, 0, 1, 0);
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
